// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and shared helpers for the HI/LO multi-cycle mul/div sequencer
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITER_CNT_W = 6;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
  function automatic logic [DEF_WIDTH-1:0] abs_if(input logic [DEF_WIDTH-1:0] v, input logic sgn);
    return (sgn && v[DEF_WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_div_step.sv
// hilo_div_step: one combinational restoring-divide step; quot shifts dividend bits out and quotient bits in
module hilo_div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quot_nxt
);
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  always_comb begin
    sh = {rem, quot[WIDTH-1]};
    diff = sh - {1'b0, divisor};
    rem_nxt = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quot_nxt = {quot[WIDTH-2:0], ~diff[WIDTH]};
  end
endmodule

// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: multi-cycle MIPS mult/div/mthi/mtlo sequencer owning HI/LO.
// HILO_FAST_MULT_EN: when defined, mult/multu complete in IDLE with a single-cycle multiply.
module hilo_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER_CNT_W = DEF_ITER_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  if (WIDTH != 32 || (1 << ITER_CNT_W) <= WIDTH) begin : g_bad_cfg
    $error("hilo_muldiv_seq supports only WIDTH=32 with a counter able to hold it");
  end
  state_e state_q, state_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, div_q, div_d, done_q, done_d, dz_q, dz_d;
  logic sgn;
  logic [WIDTH-1:0] a_abs, b_abs, rem_nxt, quot_nxt;
  logic [WIDTH:0] mul_sum;
  assign sgn = (op_code == OP_MULT) || (op_code == OP_DIV);
  assign a_abs = abs_if(op_a, sgn);
  assign b_abs = abs_if(op_b, sgn);
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  hilo_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(acc_hi_q), .quot(acc_lo_q), .divisor(opnd_q), .rem_nxt(rem_nxt), .quot_nxt(quot_nxt)
  );
`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] ax, bx, fast_p;
  assign ax = sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
  assign bx = sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
  assign fast_p = ax * bx;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d = opnd_q;
    hi_d = hi_q;
    lo_d = lo_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    div_d = div_q;
    dz_d = dz_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (op_valid) begin
        dz_d = 1'b0;
        case (op_code)
          OP_MTHI: begin hi_d = op_a; done_d = 1'b1; end
          OP_MTLO: begin lo_d = op_a; done_d = 1'b1; end
          OP_MULT, OP_MULTU: begin
`ifdef HILO_FAST_MULT_EN
            {hi_d, lo_d} = fast_p;
            done_d = 1'b1;
`else
            state_d = MUL;
            cnt_d = '0;
            acc_hi_d = '0;
            acc_lo_d = b_abs;
            opnd_d = a_abs;
            qneg_d = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rneg_d = 1'b0;
            div_d = 1'b0;
`endif
          end
          OP_DIV, OP_DIVU: if (op_b == '0) begin
            dz_d = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = DIV;
            cnt_d = '0;
            acc_hi_d = '0;
            acc_lo_d = a_abs;
            opnd_d = b_abs;
            qneg_d = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rneg_d = sgn & op_a[WIDTH-1];
            div_d = 1'b1;
          end
          default: ;
        endcase
      end
      MUL, DIV: if (cnt_q == ITER_CNT_W'(WIDTH)) begin
        state_d = FIX;
      end else begin
        cnt_d = cnt_q + ITER_CNT_W'(1);
        acc_hi_d = (state_q == MUL) ? mul_sum[WIDTH:1] : rem_nxt;
        acc_lo_d = (state_q == MUL) ? {mul_sum[0], acc_lo_q[WIDTH-1:1]} : quot_nxt;
      end
      default: begin
        state_d = IDLE;
        done_d = 1'b1;
        // div keeps quotient in acc_lo and remainder in acc_hi; mul keeps the 64-bit product
        if (div_q) begin
          lo_d = qneg_q ? -acc_lo_q : acc_lo_q;
          hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = qneg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        end
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      div_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q <= opnd_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      div_q <= div_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  assign op_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div_zero = dz_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
